if_fetch_ctrl: RTL and testbench



---
 rtl/if_fetch_ctrl_if.sv | 33 +++
 rtl/if_fetch_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: instruction-bus handshake between the fetch sequencer
// (master) and an SRAM-like instruction bus (slave).
//   inst_req/inst_addr   : request valid and address, held until inst_addr_ok
//   inst_addr_ok         : bus accepted the request this cycle
//   inst_data_ok/rdata   : bus returns read data, at the earliest one cycle
//                          after inst_addr_ok
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencer.
// Sits between the next-PC generator and the instruction bus. Issues one
// fetch at a time, strobes pc_write so the generator advances (or loads a
// redirect target), holds the returned instruction until decode accepts it,
// and discards responses belonging to fetches overtaken by a redirect.
//
// Optional feature: define IF_PERF_CNT_EN to build the fetch/cancel
// performance counters. Without it o_fetch_cnt/o_cancel_cnt are tied to 0.
module if_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              rst,
  // instruction bus
  if_fetch_ctrl_if.master   bus,
  // next-PC generator
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_pc_adel,
  input  logic              i_redirect,
  output logic              o_pc_write,
  // decode side
  input  logic              i_id_allowin,
  output logic              o_if_valid,
  output logic [31:0]       o_if_inst,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic              o_if_adel,
  // performance counters
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_cancel_cnt
);

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;  // one cycle after reset
  localparam logic [1:0] S_REQ  = 2'd1;  // request on the bus, not yet accepted
  localparam logic [1:0] S_WAIT = 2'd2;  // accepted, waiting for data
  localparam logic [1:0] S_HOLD = 2'd3;  // instruction presented to decode

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_cancel;
  logic              w_cancel_nxt;

  logic [ADDR_W-1:0] r_inst_addr;
  logic              r_if_valid;
  logic [31:0]       r_if_inst;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_if_adel;

  logic              w_in_idle;
  logic              w_in_req;
  logic              w_in_wait;
  logic              w_in_hold;
  logic              w_accept;
  logic              w_resp;
  logic              w_doomed;
  logic              w_resp_keep;
  logic              w_resp_drop;
  logic              w_hold_exit;
  logic              w_launch;
  logic              w_launch_adel;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_req  = (r_state == S_REQ);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_in_hold = (r_state == S_HOLD);

  // Bus accepted our request this cycle.
  assign w_accept = w_in_req && bus.inst_addr_ok;

  // A response is only meaningful while a fetch is outstanding.
  assign w_resp = w_in_wait && bus.inst_data_ok;

  // The in-flight fetch is stale if a redirect arrived earlier (r_cancel)
  // or arrives in the same cycle as the data.
  assign w_doomed    = r_cancel || i_redirect;
  assign w_resp_keep = w_resp && !w_doomed;
  assign w_resp_drop = w_resp &&  w_doomed;

  // Decode took the instruction, or a redirect flushes it.
  assign w_hold_exit = w_in_hold && (i_redirect || i_id_allowin);

  // Every point where a new fetch address is taken from the generator.
  assign w_launch      = w_in_idle || w_resp_drop || w_hold_exit;
  assign w_launch_adel = w_launch && i_pc_adel;

  // Advance on a clean accept; load the target on any redirect. A redirect
  // coinciding with an accept still produces a single pulse. An accept of
  // an already-cancelled request must not advance the generator again,
  // because it already holds the redirect target.
  assign o_pc_write = (w_accept && !r_cancel) || (i_redirect && !w_in_idle);

  // Next-state and cancel-flag logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    case (r_state)
      S_REQ: begin
        if (i_redirect) begin
          w_cancel_nxt = 1'b1;
        end
        if (bus.inst_addr_ok) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.inst_data_ok) begin
          // the single response of this fetch retires any pending cancel
          w_cancel_nxt = 1'b0;
          if (!w_doomed) begin
            w_state_nxt = S_HOLD;
          end
        end else if (i_redirect) begin
          w_cancel_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
    // A misaligned fetch address never reaches the bus: it is reported
    // to decode directly as an address error.
    if (w_launch) begin
      w_state_nxt = i_pc_adel ? S_HOLD : S_REQ;
    end
  end

  // State and cancel flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cancel <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cancel <= w_cancel_nxt;
    end
  end

  // Request address: captured at each launch, stable while in REQ/WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_addr <= RESET_PC;
    end else if (w_launch) begin
      r_inst_addr <= i_pc_addr;
    end
  end

  // Decode-side output buffer: filled by a clean response or an address
  // error, cleared when the held instruction leaves HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_inst  <= 32'd0;
      r_if_pc    <= RESET_PC;
      r_if_adel  <= 1'b0;
    end else if (w_resp_keep) begin
      r_if_valid <= 1'b1;
      r_if_inst  <= bus.inst_rdata;
      r_if_pc    <= r_inst_addr;
      r_if_adel  <= 1'b0;
    end else if (w_launch_adel) begin
      r_if_valid <= 1'b1;
      r_if_inst  <= 32'd0;
      r_if_pc    <= i_pc_addr;
      r_if_adel  <= 1'b1;
    end else if (w_hold_exit) begin
      r_if_valid <= 1'b0;
      r_if_adel  <= 1'b0;
    end
  end

  assign bus.inst_req  = w_in_req;
  assign bus.inst_addr = r_inst_addr;
  assign o_if_valid    = r_if_valid;
  assign o_if_inst     = r_if_inst;
  assign o_if_pc       = r_if_pc;
  assign o_if_adel     = r_if_adel;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_cancel_cnt;
  logic        w_fetch_inc;
  logic        w_cancel_inc;

  // Completed fetches include address errors delivered to decode; cancels
  // include discarded responses and held instructions flushed by redirect.
  assign w_fetch_inc  = w_resp_keep || w_launch_adel;
  assign w_cancel_inc = w_resp_drop || (w_in_hold && i_redirect && r_if_valid);

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt  <= 32'd0;
      r_cancel_cnt <= 32'd0;
    end else begin
      if (w_fetch_inc) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_cancel_inc) begin
        r_cancel_cnt <= r_cancel_cnt + 32'd1;
      end
    end
  end

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_cancel_cnt = r_cancel_cnt;
`else
  assign o_fetch_cnt  = 32'd0;
  assign o_cancel_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed test-plan sequence followed by randomized
// traffic, checked every cycle against a transaction-level fetch model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_addr = RST_PC;
  logic        pc_adel = 1'b0;
  logic        redirect = 1'b0;
  logic        id_allowin = 1'b0;
  logic        pc_write;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_adel;
  logic [31:0] fetch_cnt;
  logic [31:0] cancel_cnt;

  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.ADDR_W(32)) bus ();

  if_fetch_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .i_pc_addr    (pc_addr),
    .i_pc_adel    (pc_adel),
    .i_redirect   (redirect),
    .o_pc_write   (pc_write),
    .i_id_allowin (id_allowin),
    .o_if_valid   (if_valid),
    .o_if_inst    (if_inst),
    .o_if_pc      (if_pc),
    .o_if_adel    (if_adel),
    .o_fetch_cnt  (fetch_cnt),
    .o_cancel_cnt (cancel_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks the life of the current fetch transaction.
  bit          m_first;    // first cycle after reset, nothing launched yet
  bit          m_on_bus;   // request presented, not yet accepted
  bit          m_inflight; // accepted, response outstanding
  bit          m_stale;    // a redirect overtook the current fetch
  logic [31:0] m_addr;
  bit          m_out_v;
  logic [31:0] m_out_inst;
  logic [31:0] m_out_pc;
  bit          m_out_adel;
  logic [31:0] m_fcnt;
  logic [31:0] m_ccnt;

  // Bus responder model
  bit b_pend;
  int b_cnt;

  task automatic model_reset();
    m_first = 1; m_on_bus = 0; m_inflight = 0; m_stale = 0;
    m_addr = RST_PC; m_out_v = 0; m_out_inst = 32'd0; m_out_pc = RST_PC;
    m_out_adel = 0; m_fcnt = 32'd0; m_ccnt = 32'd0;
    b_pend = 0; b_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance models.
  // Entered and left at posedge+1.
  task automatic step(input logic red, input logic allow, input logic [31:0] pc,
                      input int aok_pct, input int dly, input logic [31:0] rd);
    bit exp_pw;
    bit take_next;
    redirect   = red;
    id_allowin = allow;
    pc_addr    = pc;
    pc_adel    = (pc[1:0] != 2'b00);
    bus.inst_addr_ok = bus.inst_req && ($urandom_range(99) < aok_pct);
    bus.inst_data_ok = b_pend && (b_cnt == 0);
    bus.inst_rdata   = rd;
    @(negedge clk);
    exp_pw = !m_first && (red || (m_on_bus && bus.inst_addr_ok && !m_stale));
    check_eq("inst_req",  {31'd0, bus.inst_req}, {31'd0, m_on_bus});
    check_eq("inst_addr", bus.inst_addr, m_addr);
    check_eq("pc_write",  {31'd0, pc_write}, {31'd0, exp_pw});
    check_eq("if_valid",  {31'd0, if_valid}, {31'd0, m_out_v});
    check_eq("if_inst",   if_inst, m_out_inst);
    check_eq("if_pc",     if_pc, m_out_pc);
    check_eq("if_adel",   {31'd0, if_adel}, {31'd0, m_out_adel});
`ifdef IF_PERF_CNT_EN
    check_eq("fetch_cnt",  fetch_cnt, m_fcnt);
    check_eq("cancel_cnt", cancel_cnt, m_ccnt);
`else
    check_eq("fetch_cnt",  fetch_cnt, 32'd0);
    check_eq("cancel_cnt", cancel_cnt, 32'd0);
`endif
    if (rst) begin
      model_reset();
    end else begin
      take_next = 0;
      if (m_first) begin
        m_first = 0;
        take_next = 1;
      end else if (m_on_bus) begin
        if (red) m_stale = 1;
        if (bus.inst_addr_ok) begin
          m_on_bus = 0;
          m_inflight = 1;
        end
      end else if (m_inflight) begin
        if (bus.inst_data_ok) begin
          m_inflight = 0;
          if (m_stale || red) begin
            m_ccnt = m_ccnt + 1;
            m_stale = 0;
            take_next = 1;
          end else begin
            m_out_v = 1; m_out_inst = rd; m_out_pc = m_addr; m_out_adel = 0;
            m_fcnt = m_fcnt + 1;
          end
        end else if (red) begin
          m_stale = 1;
        end
      end else begin
        // instruction waiting for decode
        if (red || allow) begin
          if (red) m_ccnt = m_ccnt + 1;
          m_out_v = 0; m_out_adel = 0;
          take_next = 1;
        end
      end
      if (take_next) begin
        m_addr = pc;
        if (pc[1:0] != 2'b00) begin
          m_out_v = 1; m_out_adel = 1; m_out_inst = 32'd0; m_out_pc = pc;
          m_fcnt = m_fcnt + 1;
        end else begin
          m_on_bus = 1;
        end
      end
      if (bus.inst_addr_ok) begin
        b_pend = 1; b_cnt = dly;
      end else if (bus.inst_data_ok) begin
        b_pend = 0;
      end else if (b_pend) begin
        b_cnt--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".inst_req"},  {31'd0, bus.inst_req}, 32'd0);
    check_eq({tag, ".inst_addr"}, bus.inst_addr, RST_PC);
    check_eq({tag, ".pc_write"},  {31'd0, pc_write}, 32'd0);
    check_eq({tag, ".if_valid"},  {31'd0, if_valid}, 32'd0);
    check_eq({tag, ".if_inst"},   if_inst, 32'd0);
    check_eq({tag, ".if_pc"},     if_pc, RST_PC);
    check_eq({tag, ".if_adel"},   {31'd0, if_adel}, 32'd0);
    check_eq({tag, ".fetch_cnt"}, fetch_cnt, 32'd0);
    check_eq({tag, ".cancel_cnt"}, cancel_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_outputs("rst0");
    rst = 1'b0;

    // First fetch on a zero-wait bus
    step(0, 1, RST_PC, 100, 0, $urandom);                  // IDLE
    check_eq("first_req", {31'd0, bus.inst_req}, 32'd1);
    check_eq("first_addr", bus.inst_addr, RST_PC);
    step(0, 1, 32'hbfc00004, 100, 0, $urandom);            // accepted
    step(0, 1, 32'hbfc00004, 100, 0, 32'h24020001);        // data
    check_eq("first_valid", {31'd0, if_valid}, 32'd1);
    check_eq("first_pc", if_pc, RST_PC);
    check_eq("first_inst", if_inst, 32'h24020001);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'hbfc00004, 100, 0, $urandom);
      check_eq("stall_valid", {31'd0, if_valid}, 32'd1);
      check_eq("stall_inst", if_inst, 32'h24020001);
      check_eq("stall_noreq", {31'd0, bus.inst_req}, 32'd0);
    end
    step(0, 1, 32'hbfc00004, 0, 0, $urandom);
    check_eq("after_stall_req", {31'd0, bus.inst_req}, 32'd1);
    check_eq("after_stall_addr", bus.inst_addr, 32'hbfc00004);

    // addr_ok held off for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'hbfc00008, 0, 0, $urandom);
      check_eq("slow_req", {31'd0, bus.inst_req}, 32'd1);
      check_eq("slow_addr", bus.inst_addr, 32'hbfc00004);
    end
    step(0, 1, 32'hbfc00004, 100, 1, $urandom);            // accepted, data 2 later

    // Redirect while waiting for data
    step(1, 1, 32'hbfc00380, 100, 0, $urandom);
    step(0, 1, 32'hbfc00380, 100, 0, 32'h12345678);        // stale data returns
    check_eq("redir_valid", {31'd0, if_valid}, 32'd0);
    check_eq("redir_req", {31'd0, bus.inst_req}, 32'd1);
    check_eq("redir_addr", bus.inst_addr, 32'hbfc00380);
`ifdef IF_PERF_CNT_EN
    check_eq("redir_cancel_cnt", cancel_cnt, 32'd1);
`endif

    // Misaligned fetch address
    step(0, 1, 32'hbfc00384, 100, 0, $urandom);
    step(0, 1, 32'hbfc00384, 100, 0, $urandom);
    step(0, 1, 32'hbfc00002, 100, 0, $urandom);            // decode takes, adel next
    check_eq("adel_noreq", {31'd0, bus.inst_req}, 32'd0);
    check_eq("adel_valid", {31'd0, if_valid}, 32'd1);
    check_eq("adel_flag", {31'd0, if_adel}, 32'd1);
    check_eq("adel_inst", if_inst, 32'd0);
    check_eq("adel_pc", if_pc, 32'hbfc00002);
    step(0, 0, 32'hbfc00002, 100, 0, $urandom);
    check_eq("adel_still_noreq", {31'd0, bus.inst_req}, 32'd0);
    step(0, 1, 32'hbfc00010, 100, 0, $urandom);

    // Reset while waiting for data
    step(0, 1, 32'hbfc00010, 100, 2, $urandom);
    rst = 1'b1;
    step(0, 1, 32'hbfc00014, 100, 0, $urandom);
    rst = 1'b0;
    check_reset_outputs("rst_wait");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pc = $urandom;
      if ($urandom_range(15) != 0) pc[1:0] = 2'b00;
      else if (pc[1:0] == 2'b00) pc[0] = 1'b1;
      rst = ($urandom_range(299) == 0);
      step($urandom_range(9) == 0, $urandom_range(9) < 6, pc, 60,
           $urandom_range(2), $urandom);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
